some_sub_module: RTL and testbench
==================================

# some_sub_module

Serial-to-parallel deserializer instantiated as `some_submodule` inside `pipe_pal`, including its instance arrays and generate blocks. It accepts one data bit per qualified clock cycle and emits each completed 4-bit nibble on `c`. It also assembles a `W_DATA`-bit word for the downstream datapath. It is a leaf block with no back-pressure.

## Interface
- `W_DATA`, default 32: assembled word width; must be a multiple of 4 and at least 4.
- `i_clk`  input  1  sole clock; rising-edge.
- `resetn`  input  1  asynchronous active-low reset.
- `a`  input  1  bit strobe; the bit on `b` is accepted on a rising edge where `a`=1.
- `b`  input  1  serial data bit, LSB-first.
- `c`  output  4  last completed nibble, registered.
- `c_valid`  output  1  one-cycle pulse: `c` updated this cycle.
- `word`  output  `W_DATA`  last completed word, registered.
- `word_valid`  output  1  one-cycle pulse: `word` updated this cycle.
- `parity`  output  1  XOR of all bits of `word`, registered together with it.

## Operation
- Bit counter `cnt`: 0..`W_DATA`-1, increments on each accepted bit and wraps to 0 after `W_DATA`-1.
- Nibble shift register: an accepted bit enters bit position `cnt`[1:0].
  - On the 4th accepted bit (`cnt`[1:0]==3), `c` loads the completed nibble, including the bit being accepted.
  - On that same edge `c_valid` asserts for one cycle.
- Word register: each completed nibble is written into nibble slot `cnt`/4 of the word shadow.
  - On the last bit (`cnt`==`W_DATA`-1), `word` and `parity` load from the complete shadow and `word_valid` pulses.
  - That cycle also asserts `c_valid`.
- No strobe (`a`=0): all state holds and the pulses deassert; gaps of any length are allowed.
- Partial nibbles and partial words are never visible on the outputs.

## Timing
- Reset (async assert, synchronous deassert by the parent): `cnt`, shadows, `c`, `word` and `parity` = 0; `c_valid` and `word_valid` = 0.
- Latency:
  - `c` and `c_valid` are valid immediately after the rising edge that samples the 4th bit of the nibble.
  - `word`, `parity` and `word_valid` are valid immediately after the edge that samples bit `W_DATA`-1.
- Back-to-back strobes: full rate, one bit per cycle.
  - `c_valid` pulses every 4th cycle.
  - `word_valid` pulses every `W_DATA`th cycle.
  - Both pulses are never longer than one cycle.
- Reset mid-nibble or mid-word: the partial data is discarded, and the next accepted bit is bit 0.
- `b` is ignored when `a`=0, including X on `b`.

## Structure
- Shared package:
  - `NIBBLE_W`=4.
  - Function `clog2` for the `cnt` width, `$clog2(W_DATA)`, minimum 2.
- One natural sub-module, `nibble_shifter`:
  - Holds the 4-bit shift register and the local 2-bit count.
  - Outputs the nibble and its done pulse.
  - The top level handles word assembly and parity.

## Test plan
- Reset: hold `resetn`=0 with random `a` and `b` → all outputs 0, no pulses; release → still 0 until 4 bits are strobed.
- Nibble: strobe bits 1,0,1,1 on consecutive cycles → `c`=4'b1101 with `c_valid`=1 for exactly one cycle, after the 4th edge.
- Gaps: the same 4 bits with `a`=0 for 3 cycles between each → same `c`, one pulse, no earlier pulses.
- Word (`W_DATA`=32): stream 0xDEADBEEF LSB-first at full rate.
  - `c_valid` pulses 8 times.
  - `word`=0xDEADBEEF, `parity`=0 (24 ones), and `word_valid` pulses once, together with the 8th `c_valid`.
- Reset mid-word: assert `resetn` after 10 bits, then stream 0x0000000F → `word`=0x0000000F, `parity`=0.
- Wrap: two consecutive words 0x12345678 then 0xFFFFFFFF → both reported correctly, and `parity` of the second is 0.

Source files
------------

// File: rtl/some_sub_module_pkg.sv
// Shared constants and helpers for the serial-to-parallel deserializer.
package some_sub_module_pkg;

   localparam int NIBBLE_W = 4;

   // Bit-counter width; never narrower than the 2-bit in-nibble index.
   function automatic int clog2(input int n);
      int r;
      r = $clog2(n);
      return (r < 2) ? 2 : r;
   endfunction

endpackage

// File: rtl/some_sub_module_if.sv
// Serial input strobe/data and parallel nibble/word results of the deserializer.
interface some_sub_module_if #(
   parameter int W_DATA = 32
) ();

   logic              a;
   logic              b;
   logic [3:0]        c;
   logic              c_valid;
   logic [W_DATA-1:0] word;
   logic              word_valid;
   logic              parity;

   modport master (
      output a, b,
      input  c, c_valid, word, word_valid, parity
   );

   modport slave (
      input  a, b,
      output c, c_valid, word, word_valid, parity
   );

endinterface

// File: rtl/some_sub_module_nibble_shifter.sv
// Collects strobed serial bits LSB-first into a 4-bit nibble and reports each completed one.
module nibble_shifter
   import some_sub_module_pkg::*;
(
   input  logic                i_clk,
   input  logic                resetn,
   input  logic                a,
   input  logic                b,
   output logic [NIBBLE_W-1:0] fill,
   output logic [NIBBLE_W-1:0] nib,
   output logic                done
);

   logic [1:0]          pos;
   logic [NIBBLE_W-1:0] sr;
   logic                last;

   // Shift register with the bit being accepted already merged in.
   always_comb begin
      fill      = sr;
      fill[pos] = b;
   end

   assign last = a && (pos == 2'd3);

   always_ff @(posedge i_clk or negedge resetn) begin
      if (!resetn) begin
         pos  <= 2'd0;
         sr   <= '0;
         nib  <= '0;
         done <= 1'b0;
      end else begin
         done <= last;
         if (a) begin
            pos <= pos + 2'd1;
            sr  <= fill;
            if (last)
               nib <= fill;
         end
      end
   end

endmodule

// File: rtl/some_sub_module.sv
// Deserializer top: nibbles come from the shifter, words and parity are assembled here.
module some_sub_module
   import some_sub_module_pkg::*;
#(
   parameter int W_DATA = 32
) (
   input  logic            i_clk,
   input  logic            resetn,
   some_sub_module_if.slave bus
);

   localparam int CNT_W = clog2(W_DATA);

   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    slot_lsb;
   logic [W_DATA-1:0]   shadow;
   logic [W_DATA-1:0]   word_full;
   logic [W_DATA-1:0]   word_q;
   logic [NIBBLE_W-1:0] fill;
   logic [NIBBLE_W-1:0] nib;
   logic                nib_done;
   logic                nib_last;
   logic                last_bit;
   logic                parity_q;
   logic                word_valid_q;

   nibble_shifter u_nibble_shifter (
      .i_clk  (i_clk),
      .resetn (resetn),
      .a      (bus.a),
      .b      (bus.b),
      .fill   (fill),
      .nib    (nib),
      .done   (nib_done)
   );

   assign nib_last = (cnt[1:0] == 2'd3);
   assign last_bit = (cnt == CNT_W'(W_DATA - 1));
   assign slot_lsb = cnt & ~CNT_W'(3);

   // Word shadow with the nibble completing on this edge already in its slot.
   always_comb begin
      word_full                       = shadow;
      word_full[slot_lsb +: NIBBLE_W] = fill;
   end

   always_ff @(posedge i_clk or negedge resetn) begin
      if (!resetn) begin
         cnt          <= '0;
         shadow       <= '0;
         word_q       <= '0;
         parity_q     <= 1'b0;
         word_valid_q <= 1'b0;
      end else begin
         word_valid_q <= bus.a && last_bit;
         if (bus.a) begin
            cnt <= last_bit ? '0 : cnt + CNT_W'(1);
            if (nib_last)
               shadow <= word_full;
            if (last_bit) begin
               word_q   <= word_full;
               parity_q <= ^word_full;
            end
         end
      end
   end

   assign bus.c          = nib;
   assign bus.c_valid    = nib_done;
   assign bus.word       = word_q;
   assign bus.word_valid = word_valid_q;
   assign bus.parity     = parity_q;

endmodule

// File: tb/tb_some_sub_module.sv
// Randomized and directed checks of the deserializer against a word-level reference model.
module tb_some_sub_module;

   localparam int W = 32;

   logic i_clk  = 1'b0;
   logic resetn = 1'b0;

   always #5 i_clk = ~i_clk;

   some_sub_module_if #(.W_DATA(W)) bus ();

   some_sub_module #(.W_DATA(W)) dut (
      .i_clk  (i_clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state: bits accumulated so far and the expected outputs.
   int         m_cnt;
   logic [W-1:0] m_word;
   logic [3:0] e_c;
   logic       e_cv;
   logic       e_wv;
   logic       e_par;
   logic [W-1:0] e_word;
   int         cv_seen;
   int         wv_seen;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt  = 0;
      m_word = '0;
      e_c    = '0;
      e_cv   = 1'b0;
      e_wv   = 1'b0;
      e_par  = 1'b0;
      e_word = '0;
   endtask

   task automatic compare_all();
      check("c",          64'(bus.c),          64'(e_c));
      check("c_valid",    64'(bus.c_valid),    64'(e_cv));
      check("word",       64'(bus.word),       64'(e_word));
      check("word_valid", 64'(bus.word_valid), 64'(e_wv));
      check("parity",     64'(bus.parity),     64'(e_par));
   endtask

   task automatic step(input logic ia, input logic ib);
      @(negedge i_clk);
      bus.a = ia;
      bus.b = ia ? ib : 1'bx;
      @(posedge i_clk);
      #1;
      e_cv = 1'b0;
      e_wv = 1'b0;
      if (ia) begin
         m_word[m_cnt] = ib;
         if (m_cnt % 4 == 3) begin
            e_c  = m_word[m_cnt-3 +: 4];
            e_cv = 1'b1;
         end
         if (m_cnt == W - 1) begin
            e_word = m_word;
            e_par  = ^m_word;
            e_wv   = 1'b1;
            m_cnt  = 0;
         end else begin
            m_cnt++;
         end
      end
      if (bus.c_valid)    cv_seen++;
      if (bus.word_valid) wv_seen++;
      compare_all();
   endtask

   // Async assert off the clock edge, random inputs while held, release on a falling edge.
   task automatic reset_phase(input int n);
      @(negedge i_clk);
      #2;
      resetn = 1'b0;
      #1;
      model_reset();
      compare_all();
      for (int i = 0; i < n; i++) begin
         @(negedge i_clk);
         bus.a = 1'($urandom);
         bus.b = 1'($urandom);
         @(posedge i_clk);
         #1;
         compare_all();
      end
      @(negedge i_clk);
      resetn = 1'b1;
      bus.a  = 1'b0;
   endtask

   task automatic send_word(input logic [W-1:0] w, input int max_gap);
      for (int i = 0; i < W; i++) begin
         step(1'b1, w[i]);
         if (max_gap > 0)
            repeat ($urandom_range(0, max_gap)) step(1'b0, 1'b0);
      end
   endtask

   initial begin
      logic [3:0] pat;
      pat   = 4'b1101;
      bus.a = 1'b0;
      bus.b = 1'b0;
      model_reset();

      reset_phase(6);

      // First nibble at full rate; nothing visible until the 4th bit.
      cv_seen = 0;
      for (int i = 0; i < 4; i++) step(1'b1, pat[i]);
      check("nib_c", 64'(bus.c), 64'h0D);
      check("nib_c_valid", 64'(bus.c_valid), 64'h1);
      step(1'b0, 1'b0);
      check("nib_pulse_count", 64'(cv_seen), 64'd1);

      // Same nibble with 3-cycle gaps between bits.
      cv_seen = 0;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, pat[i]);
         if (i < 3) repeat (3) step(1'b0, 1'b0);
      end
      check("gap_c", 64'(bus.c), 64'h0D);
      check("gap_pulse_count", 64'(cv_seen), 64'd1);

      // Full word at full rate.
      reset_phase(2);
      cv_seen = 0;
      wv_seen = 0;
      send_word(32'hDEADBEEF, 0);
      check("dead_word", 64'(bus.word), 64'hDEADBEEF);
      check("dead_parity", 64'(bus.parity), 64'h0);
      check("dead_cv_count", 64'(cv_seen), 64'd8);
      check("dead_wv_count", 64'(wv_seen), 64'd1);

      // Reset after 10 bits discards the partial word.
      for (int i = 0; i < 10; i++) step(1'b1, 1'($urandom));
      reset_phase(3);
      send_word(32'h0000000F, 0);
      check("mid_word", 64'(bus.word), 64'h0000000F);
      check("mid_parity", 64'(bus.parity), 64'h0);

      // Back-to-back words across the counter wrap.
      send_word(32'h12345678, 0);
      check("wrap1_word", 64'(bus.word), 64'h12345678);
      check("wrap1_parity", 64'(bus.parity), 64'h1);
      send_word(32'hFFFFFFFF, 0);
      check("wrap2_word", 64'(bus.word), 64'hFFFFFFFF);
      check("wrap2_parity", 64'(bus.parity), 64'h0);

      // Random words with random gaps.
      for (int k = 0; k < 6; k++) begin
         logic [W-1:0] rw;
         rw = W'($urandom);
         send_word(rw, 2);
         check("rand_word", 64'(bus.word), 64'(rw));
         check("rand_parity", 64'(bus.parity), 64'(^rw));
      end

      // Free-running random strobes with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0)
            reset_phase(int'($urandom_range(1, 3)));
         else
            step($urandom_range(0, 3) != 0, 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
